// File: rtl/exibidor_sequencia_if.sv
// exibidor_sequencia_if
// Groups every signal exchanged between the sequence display block, the
// game FSM and the pattern ROM. The display block uses the slave modport.
// The controlling side (game FSM plus ROM) uses the master modport.
//   iniciar      start request from the game FSM
//   abortar      synchronous abort from the game FSM
//   comprimento  index of the last item to show (items = comprimento+1)
//   dado_rom     ROM data for the current endereco, one cycle late
//   endereco     ROM address driven by the display block
//   leds         LED drive for the four player LEDs
//   ocupado      sequence in progress
//   pronto       one-cycle pulse when the whole sequence has been shown
//   db_estado    current FSM state code, for debug displays
interface exibidor_sequencia_if;
    logic       iniciar;
    logic       abortar;
    logic [3:0] comprimento;
    logic [3:0] dado_rom;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar,
        input  abortar,
        input  comprimento,
        input  dado_rom,
        output endereco,
        output leds,
        output ocupado,
        output pronto,
        output db_estado
    );

    modport master (
        output iniciar,
        output abortar,
        output comprimento,
        output dado_rom,
        input  endereco,
        input  leds,
        input  ocupado,
        input  pronto,
        input  db_estado
    );
endinterface

// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia
// This block is the presentation end of the MindFocus play loop. It reads the
// target pattern from a 16x4 synchronous ROM. It flashes one item at a time
// on the four player LEDs, with a dark gap after each item. It then pulses
// pronto so the game FSM can start accepting button presses.
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high, highest priority
//   bus     exibidor_sequencia_if.slave. Carries these signals:
//           iniciar, abortar, comprimento and dado_rom (inputs);
//           endereco, leds, ocupado, pronto and db_estado (outputs).
// Parameters:
//   ON_CYCLES   cycles each item stays lit (>= 1)
//   OFF_CYCLES  dark cycles after each item (>= 1)
module exibidor_sequencia #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic                   clock,
    input  logic                   reset,
    exibidor_sequencia_if.slave    bus
);

    // Timer only ever counts up to the larger of the two phase lengths minus one.
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ESPERA_ROM = 3'd1,
        CAPTURA    = 3'd2,
        ACENDE     = 3'd3,
        APAGA      = 3'd4,
        PROXIMO    = 3'd5,
        FIM        = 3'd6
    } estado_t;

    estado_t        r_estado;
    logic [TW-1:0]  r_timer;
    logic [3:0]     r_ult;
    logic [3:0]     r_item;
    logic [3:0]     r_endereco;
    logic [3:0]     r_leds;
    logic           r_ocupado;
    logic           r_pronto;

    // This is the sequencing FSM. Every output register is updated together
    // with the state it belongs to, so the outputs always match r_estado.
    // Abort clears the same registers that reset clears, so the two share
    // one branch. Abort also wins over a simultaneous iniciar.
    // The ROM is synchronous. ESPERA_ROM gives it one cycle to present the
    // word for the new address, and CAPTURA then stores that word.
    // comprimento is latched at start. Changes while busy have no effect.
    always_ff @(posedge clock) begin
        if (reset || bus.abortar) begin
            r_estado   <= OCIOSO;
            r_timer    <= '0;
            r_ult      <= 4'd0;
            r_item     <= 4'd0;
            r_endereco <= 4'd0;
            r_leds     <= 4'd0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        r_ult      <= bus.comprimento;
                        r_endereco <= 4'd0;
                        r_ocupado  <= 1'b1;
                        r_estado   <= ESPERA_ROM;
                    end
                end
                ESPERA_ROM: begin
                    r_estado <= CAPTURA;
                end
                CAPTURA: begin
                    r_item   <= bus.dado_rom;
                    r_leds   <= bus.dado_rom;
                    r_timer  <= '0;
                    r_estado <= ACENDE;
                end
                ACENDE: begin
                    // An all-zero item is still given its full lit slot.
                    // The LEDs simply stay dark for that slot.
                    if (r_timer == ON_LAST) begin
                        r_timer  <= '0;
                        r_leds   <= 4'd0;
                        r_estado <= APAGA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        r_leds  <= r_item;
                    end
                end
                APAGA: begin
                    if (r_timer == OFF_LAST) begin
                        r_timer  <= '0;
                        r_estado <= PROXIMO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                PROXIMO: begin
                    // The address stops at the last item, so it never wraps.
                    // It keeps that value after FIM until the next start.
                    if (r_endereco == r_ult) begin
                        r_pronto <= 1'b1;
                        r_estado <= FIM;
                    end else begin
                        r_endereco <= r_endereco + 4'd1;
                        r_estado   <= ESPERA_ROM;
                    end
                end
                FIM: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.endereco  = r_endereco;
    assign bus.leds      = r_leds;
    assign bus.ocupado   = r_ocupado;
    assign bus.pronto    = r_pronto;
    assign bus.db_estado = {1'b0, r_estado};

endmodule

// File: tb/tb_exibidor_sequencia.sv
// tb_exibidor_sequencia
// Self-checking bench for exibidor_sequencia with short phases (4 lit, 2 dark).
// A small synchronous ROM model feeds dado_rom. Expected items go into a
// queue at start time. They are popped and compared each time the DUT
// enters its lit state.
// Ports: none (top-level bench).
module tb_exibidor_sequencia;

    localparam int ON_CYC  = 4;
    localparam int OFF_CYC = 2;

    logic clock;
    logic reset;

    exibidor_sequencia_if bus();

    exibidor_sequencia #(
        .ON_CYCLES (ON_CYC),
        .OFF_CYCLES(OFF_CYC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] leds;
        logic [3:0] addr;
    } item_t;

    typedef struct {
        logic [3:0] comp;
        int         expDelay;
        logic [3:0] expLast;
    } vec_t;

    logic [3:0] rom [16];
    item_t      expQ[$];
    vec_t       vecs[4];
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         prontoCount = 0;
    bit         monOn       = 0;
    logic [3:0] prevEstado  = 4'd0;
    int         onCount     = 0;
    int         offCount    = 0;

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // The ROM is synchronous. It presents the word for endereco one cycle later.
    always @(posedge clock) begin
        bus.dado_rom <= rom[bus.endereco];
    end

    // Records one comparison. A mismatch prints a FAIL line with both values.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // This monitor samples on the falling edge. Each entry into the lit state
    // pops one expected item. The LEDs must be dark in every other state. The
    // lengths of the lit and dark phases are measured and checked.
    always @(negedge clock) begin
        item_t e;
        if (monOn) begin
            if (bus.pronto) prontoCount++;
            if (bus.db_estado == 4'd3) begin
                if (prevEstado != 4'd3) begin
                    onCount = 1;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected item shown", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("item leds", int'(bus.leds), int'(e.leds));
                        checkOutput("item endereco", int'(bus.endereco), int'(e.addr));
                    end
                end else begin
                    onCount++;
                end
            end else begin
                checkOutput("leds dark", int'(bus.leds), 0);
                if (prevEstado == 4'd3 && bus.db_estado == 4'd4)
                    checkOutput("on duration", onCount, ON_CYC);
                if (bus.db_estado == 4'd4)
                    offCount = (prevEstado == 4'd4) ? offCount + 1 : 1;
                if (prevEstado == 4'd4 && bus.db_estado == 4'd5)
                    checkOutput("off duration", offCount, OFF_CYC);
            end
            prevEstado = bus.db_estado;
        end
    end

    // Pulses iniciar for one cycle and queues the items the DUT should show.
    task automatic applyStimulus(input logic [3:0] comp);
        bus.comprimento = comp;
        bus.iniciar     = 1'b1;
        for (int i = 0; i <= int'(comp); i++)
            expQ.push_back('{leds: rom[i], addr: 4'(i)});
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    // Waits, with a cycle bound, for the given state code. An address of -1
    // means any address is accepted.
    task automatic waitUntil(input string name, input logic [3:0] st, input int addr);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clock);
            if (bus.db_estado == st && (addr < 0 || int'(bus.endereco) == addr)) hit = 1;
        end
        if (!hit) checkOutput({name, " wait timeout"}, 0, 1);
    endtask

    // This task starts one cycle after the accept edge. It counts cycles
    // until the pronto pulse and checks the end-of-sequence outputs.
    // glitchAt > 0 re-pulses iniciar with a new comprimento at that cycle.
    task automatic waitPronto(input string name, input int expDelay,
                              input logic [3:0] expLast, input int glitchAt);
        int cycles = 0;
        bit seen   = 0;
        checkOutput({name, " ocupado after accept"}, int'(bus.ocupado), 1);
        while (!seen && cycles < 400) begin
            @(negedge clock);
            cycles++;
            if (glitchAt != 0) begin
                bus.iniciar = (cycles == glitchAt);
                if (cycles == glitchAt) bus.comprimento = 4'd1;
            end
            if (bus.pronto) seen = 1;
        end
        checkOutput({name, " pronto delay"}, seen ? cycles : -1, expDelay);
        checkOutput({name, " ocupado in FIM"}, int'(bus.ocupado), 1);
        checkOutput({name, " estado FIM"}, int'(bus.db_estado), 6);
        checkOutput({name, " endereco at FIM"}, int'(bus.endereco), int'(expLast));
        @(negedge clock);
        bus.iniciar = 1'b0;
        checkOutput({name, " pronto single pulse"}, int'(bus.pronto), 0);
        checkOutput({name, " ocupado after FIM"}, int'(bus.ocupado), 0);
        checkOutput({name, " estado idle"}, int'(bus.db_estado), 0);
        checkOutput({name, " endereco held"}, int'(bus.endereco), int'(expLast));
        checkOutput({name, " items left"}, expQ.size(), 0);
        expQ.delete();
    endtask

    // This is a safety net, so that the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // This is the main test sequence. First come the table-driven normal runs,
    // then the multi-cycle corner cases.
    initial begin
        int p0;
        rom[0]  = 4'b0001; rom[1]  = 4'b0010; rom[2]  = 4'b0100; rom[3]  = 4'b1000;
        rom[4]  = 4'b1111; rom[5]  = 4'b0000; rom[6]  = 4'b0011; rom[7]  = 4'b1100;
        rom[8]  = 4'b0101; rom[9]  = 4'b1010; rom[10] = 4'b0110; rom[11] = 4'b1001;
        rom[12] = 4'b0111; rom[13] = 4'b1110; rom[14] = 4'b1011; rom[15] = 4'b1101;

        vecs[0] = '{4'd3,  36,  4'd3};
        vecs[1] = '{4'd0,  9,   4'd0};
        vecs[2] = '{4'd1,  18,  4'd1};
        vecs[3] = '{4'd15, 144, 4'd15};

        reset           = 1'b1;
        bus.iniciar     = 1'b0;
        bus.abortar     = 1'b0;
        bus.comprimento = 4'd0;
        repeat (3) @(negedge clock);
        checkOutput("reset estado", int'(bus.db_estado), 0);
        checkOutput("reset endereco", int'(bus.endereco), 0);
        checkOutput("reset leds", int'(bus.leds), 0);
        checkOutput("reset ocupado", int'(bus.ocupado), 0);
        checkOutput("reset pronto", int'(bus.pronto), 0);
        reset      = 1'b0;
        prevEstado = 4'd0;
        monOn      = 1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].comp);
            waitPronto($sformatf("vec%0d", i), vecs[i].expDelay, vecs[i].expLast, 0);
        end

        // Abort during the second lit item. No pronto may follow.
        applyStimulus(4'd3);
        waitUntil("abort", 4'd3, 1);
        bus.abortar = 1'b1;
        @(negedge clock);
        bus.abortar = 1'b0;
        checkOutput("abort leds", int'(bus.leds), 0);
        checkOutput("abort estado", int'(bus.db_estado), 0);
        checkOutput("abort ocupado", int'(bus.ocupado), 0);
        checkOutput("abort endereco", int'(bus.endereco), 0);
        expQ.delete();
        p0 = prontoCount;
        repeat (40) @(negedge clock);
        checkOutput("abort no pronto", prontoCount - p0, 0);

        // abortar and iniciar in the same idle cycle: abort wins.
        bus.comprimento = 4'd0;
        bus.iniciar     = 1'b1;
        bus.abortar     = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        checkOutput("abort+iniciar estado", int'(bus.db_estado), 0);
        checkOutput("abort+iniciar ocupado", int'(bus.ocupado), 0);
        p0 = prontoCount;
        repeat (12) @(negedge clock);
        checkOutput("abort+iniciar no pronto", prontoCount - p0, 0);

        // Re-pulsing iniciar with a new comprimento mid-run changes nothing.
        applyStimulus(4'd3);
        waitPronto("ignore restart", 36, 4'd3, 12);

        // Reset in the dark phase, then a clean restart from address 0.
        applyStimulus(4'd3);
        waitUntil("reset mid", 4'd4, -1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid reset estado", int'(bus.db_estado), 0);
        checkOutput("mid reset endereco", int'(bus.endereco), 0);
        checkOutput("mid reset leds", int'(bus.leds), 0);
        checkOutput("mid reset ocupado", int'(bus.ocupado), 0);
        expQ.delete();
        @(negedge clock);
        applyStimulus(4'd1);
        waitPronto("restart", 18, 4'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
